// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter.
// State encoding, requester indices and counter width.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] IDX_A = 2'd3;
    localparam logic [1:0] IDX_B = 2'd2;
    localparam logic [1:0] IDX_C = 2'd1;
    localparam logic [1:0] IDX_D = 2'd0;

    localparam int CNT_W = 8;

endpackage

// File: rtl/masked_priority_encoder4.sv
// Four-input priority encoder with a movable start index.
// Search order: start, start-1, ... wrapping 0->3.
module masked_priority_encoder4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [3:0] winner,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand;

    // Scan lowest priority first so the start index overwrites last
    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = start - 2'(k);
            if (req[cand]) begin
                winner = 4'b0001 << cand;
                idx    = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_ctrl.sv
// Four-way arbiter: held one-hot grant, done/withdraw release,
// bounded hold time, optional rotating priority.
module priority_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int TIMEOUT     = 8,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout_pulse
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [3:0]       grant_nx;
    logic [1:0]       idx_nx;
    logic             busy_nx;
    logic             tp_nx;
    logic             rel;

    logic [1:0] start;
    logic [3:0] enc_win;
    logic [1:0] enc_idx;
    logic       enc_valid;

    // Rotating mode starts one below the last served index
    assign start = ROUND_ROBIN ? (ptr - 2'd1) : IDX_A;

    masked_priority_encoder4 u_enc (
        .req    (req),
        .start  (start),
        .winner (enc_win),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // Next-state and registered-output decisions
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        grant_nx = grant;
        idx_nx   = grant_idx;
        busy_nx  = busy;
        tp_nx    = 1'b0;
        rel      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nx = GRANT;
                    grant_nx = enc_win;
                    idx_nx   = enc_idx;
                    busy_nx  = 1'b1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (done || !req[grant_idx]) begin
                    rel = 1'b1;
                end else if (cnt == TMO) begin
                    rel   = 1'b1;
                    tp_nx = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
                if (rel) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    idx_nx   = '0;
                    busy_nx  = 1'b0;
                    cnt_nx   = '0;
                    ptr_nx   = grant_idx;
                end
            end
        endcase
    end

    // State, counter, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= IDX_D;
            grant         <= '0;
            grant_idx     <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            ptr           <= ptr_nx;
            grant         <= grant_nx;
            grant_idx     <= idx_nx;
            busy          <= busy_nx;
            timeout_pulse <= tp_nx;
        end
    end

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
// Scoreboard bench: fixed and rotating instances share stimulus,
// an abstract model queues expectations, a monitor compares.
module tb_priority_arbiter_ctrl;

    localparam int TMO = 8;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic       busy;
        logic       tp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic       done = 1'b0;

    logic [3:0] g_fp, g_rr;
    logic [1:0] i_fp, i_rr;
    logic       b_fp, b_rr;
    logic       t_fp, t_rr;

    int total = 0;
    int bad = 0;

    exp_t sb[2][$];
    int   holder[2] = '{-1, -1};
    int   hlen[2]   = '{0, 0};
    int   last[2]   = '{0, 0};
    bit   pls[2]    = '{0, 0};
    int   run[2]    = '{0, 0};
    int   tp_seen = 0;

    always #5 clk = ~clk;

    priority_arbiter_ctrl #(.TIMEOUT(TMO), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(g_fp), .grant_idx(i_fp), .busy(b_fp),
        .timeout_pulse(t_fp)
    );

    priority_arbiter_ctrl #(.TIMEOUT(TMO), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(g_rr), .grant_idx(i_rr), .busy(b_rr),
        .timeout_pulse(t_rr)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int m, input logic [3:0] r);
        int i;
        if (m == 0) begin
            for (int k = 3; k >= 0; k--) if (r[k]) return k;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                i = (last[m] + 4 - k) % 4;
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        exp_t e;
        pls[m] = 0;
        if (holder[m] < 0) begin
            if (req != 0) begin
                holder[m] = pick(m, req);
                hlen[m]   = 1;
            end
        end else if (done || !req[holder[m]]) begin
            last[m]   = holder[m];
            holder[m] = -1;
        end else if (hlen[m] == TMO) begin
            last[m]   = holder[m];
            holder[m] = -1;
            pls[m]    = 1;
        end else begin
            hlen[m]++;
        end
        e.g    = (holder[m] < 0) ? 4'b0 : 4'(1 << holder[m]);
        e.idx  = (holder[m] < 0) ? 2'd0 : 2'(holder[m]);
        e.busy = (holder[m] >= 0);
        e.tp   = pls[m];
        sb[m].push_back(e);
    endtask

    // Reference model: advance on each edge, queue expectations
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                holder[m] = -1;
                hlen[m]   = 0;
                last[m]   = 0;
                pls[m]    = 0;
                sb[m].delete();
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Monitor: pop and compare away from the active edge
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] g;
        logic [1:0] ix;
        logic bz, tp;
        string nm;
        for (int m = 0; m < 2; m++) begin
            g  = m == 0 ? g_fp : g_rr;
            ix = m == 0 ? i_fp : i_rr;
            bz = m == 0 ? b_fp : b_rr;
            tp = m == 0 ? t_fp : t_rr;
            nm = m == 0 ? "fp" : "rr";
            if (!rst_n) begin
                check({nm, ".rst_grant"}, int'(g), 0);
                check({nm, ".rst_busy"}, int'(bz), 0);
                check({nm, ".rst_tp"}, int'(tp), 0);
                run[m] = 0;
            end else if (sb[m].size() > 0) begin
                e = sb[m].pop_front();
                check({nm, ".grant"}, int'(g), int'(e.g));
                check({nm, ".idx"}, int'(ix), int'(e.idx));
                check({nm, ".busy"}, int'(bz), int'(e.busy));
                check({nm, ".tpulse"}, int'(tp), int'(e.tp));
                if (g != 0) run[m]++;
                else run[m] = 0;
                if (run[m] > TMO)
                    check({nm, ".hold_len"}, run[m], TMO);
                if (m == 0 && tp) tp_seen++;
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic d, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            req  = r;
            done = d;
        end
    endtask

    task automatic mid_grant_reset();
        int w = 0;
        step(4'b0100, 1'b0, 1);
        while (g_fp == 0 && w < 20) begin
            step(4'b0100, 1'b0, 1);
            w++;
        end
        check("mrst.wait_grant", int'(g_fp != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.fp_grant", int'(g_fp), 0);
        check("mrst.rr_grant", int'(g_rr), 0);
        check("mrst.fp_busy", int'(b_fp), 0);
        check("mrst.rr_busy", int'(b_rr), 0);
        step(4'b0000, 1'b0, 2);
        rst_n = 1'b1;
    endtask

    initial begin
        step(4'b1111, 1'b0, 2);
        rst_n = 1'b1;
        req   = 4'b0110;
        step(4'b0110, 1'b0, 2);
        step(4'b0110, 1'b1, 1);
        step(4'b0001, 1'b0, 3);
        step(4'b1001, 1'b0, 3);
        step(4'b1001, 1'b1, 1);
        step(4'b1001, 1'b0, 2);
        step(4'b1001, 1'b1, 1);
        step(4'b0010, 1'b0, 12);
        step(4'b0000, 1'b0, 2);
        step(4'b1111, 1'b1, 12);
        step(4'b0000, 1'b0, 2);
        step(4'b0010, 1'b0, 8);
        step(4'b0010, 1'b1, 1);
        step(4'b0000, 1'b0, 2);
        step(4'b0100, 1'b0, 3);
        step(4'b0000, 1'b0, 2);
        mid_grant_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 9) == 0);
        end
        mid_grant_reset();
        step(4'b0000, 1'b0, 3);
        check("timeout_pulses_seen", int'(tp_seen > 0), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
